// File: rtl/hex_mem_arbiter_if.sv
// Bundle of the N request ports and the shared memory port of hex_mem_arbiter.
// The arbiter takes the slave view; the requesters and the memory take the master view.
interface hex_mem_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [N_REQ-1:0]        i_req_valid;
   logic [N_REQ-1:0]        o_req_ready;
   logic [N_REQ-1:0]        i_req_we;
   logic [N_REQ*ADDR_W-1:0] i_req_addr;
   logic [N_REQ*DATA_W-1:0] i_req_data;
   logic [N_REQ-1:0]        o_rsp_valid;
   logic [DATA_W-1:0]       o_rsp_data;
   logic                    o_m_valid;
   logic                    o_m_we;
   logic [ADDR_W-1:0]       o_m_addr;
   logic [DATA_W-1:0]       o_m_data;
   logic [DATA_W-1:0]       i_m_data;

   modport slave (
      input  i_req_valid, i_req_we, i_req_addr, i_req_data, i_m_data,
      output o_req_ready, o_rsp_valid, o_rsp_data,
      output o_m_valid, o_m_we, o_m_addr, o_m_data
   );

   modport master (
      output i_req_valid, i_req_we, i_req_addr, i_req_data, i_m_data,
      input  o_req_ready, o_rsp_valid, o_rsp_data,
      input  o_m_valid, o_m_we, o_m_addr, o_m_data
   );
endinterface

// File: rtl/hex_mem_arbiter.sv
// N-port arbiter (round-robin or fixed priority) in front of one single-port memory,
// routing each read response back to its issuing port through a tag pipeline.
module hex_mem_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int RD_LAT    = 1,
   parameter int PRIO_MODE = 0
) (
   input logic              i_clk,
   input logic              i_rst,
   hex_mem_arbiter_if.slave bus
);
   localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
      $error("hex_mem_arbiter: N_REQ must be within 2..16");
   end
   if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
      $error("hex_mem_arbiter: RD_LAT must be within 1..8");
   end
   if (PRIO_MODE != 0 && PRIO_MODE != 1) begin : g_bad_prio_mode
      $error("hex_mem_arbiter: PRIO_MODE must be 0 or 1");
   end

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] id;
   } tag_t;

   logic [ADDR_W-1:0] req_addr [N_REQ];
   logic [DATA_W-1:0] req_data [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
      assign req_addr[k] = bus.i_req_addr[k*ADDR_W +: ADDR_W];
      assign req_data[k] = bus.i_req_data[k*DATA_W +: DATA_W];
   end

   logic [N_REQ-1:0]  grant;
   logic [TAG_W-1:0]  grant_id;
   logic [TAG_W-1:0]  cand;
   logic              accept;
   logic [TAG_W-1:0]  ptr_q, ptr_d;
   logic              m_valid_q, m_we_q;
   logic [ADDR_W-1:0] m_addr_q;
   logic [DATA_W-1:0] m_data_q;
   logic [N_REQ-1:0]  rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   tag_t              tag_q [RD_LAT+1];

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the search infers a latch.
      grant    = '0;
      grant_id = '0;
      cand     = '0;
      accept   = 1'b0;
      ptr_d    = ptr_q;
      // Nothing is granted while reset is asserted, so ready is low during reset.
      if (i_rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            cand = (PRIO_MODE == 1) ? TAG_W'(i) : TAG_W'((int'(ptr_q) + i) % N_REQ);
            if (!accept && bus.i_req_valid[cand]) begin
               accept      = 1'b1;
               grant_id    = cand;
               grant[cand] = 1'b1;
            end
         end
      end
      if (accept) begin
         ptr_d = (grant_id == TAG_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

   // NOTE: sequential state is updated with <= only, so every register sees pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         ptr_q       <= '0;
         m_valid_q   <= 1'b0;
         m_we_q      <= 1'b0;
         m_addr_q    <= '0;
         m_data_q    <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         // NOTE: the tag pipeline is control state, not storage, so it is cleared; this drops in-flight reads.
         for (int k = 0; k <= RD_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         ptr_q     <= ptr_d;
         m_valid_q <= accept;
         m_we_q    <= accept && bus.i_req_we[grant_id];
         if (accept) begin
            m_addr_q <= req_addr[grant_id];
            m_data_q <= req_data[grant_id];
         end
         tag_q[0].vld <= accept && !bus.i_req_we[grant_id];
         tag_q[0].id  <= grant_id;
         for (int k = 1; k <= RD_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
         // Stage RD_LAT lines up with the cycle in which the memory presents read data.
         rsp_valid_q <= '0;
         if (tag_q[RD_LAT].vld) begin
            rsp_valid_q <= N_REQ'(1) << tag_q[RD_LAT].id;
            rsp_data_q  <= bus.i_m_data;
         end
      end
   end

   assign bus.o_req_ready = grant;
   assign bus.o_m_valid   = m_valid_q;
   assign bus.o_m_we      = m_we_q;
   assign bus.o_m_addr    = m_addr_q;
   assign bus.o_m_data    = m_data_q;
   assign bus.o_rsp_valid = rsp_valid_q;
   assign bus.o_rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_hex_mem_arbiter.sv
// Directed bench: one round-robin arbiter with RD_LAT=1 and one fixed-priority arbiter
// with RD_LAT=4, each in front of a small behavioural memory.
module tb_hex_mem_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   hex_mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) a_if ();
   hex_mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) b_if ();

   hex_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PRIO_MODE(0)) dut_a (
      .i_clk (clk),
      .i_rst (rst_a),
      .bus   (a_if)
   );

   hex_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(4), .PRIO_MODE(1)) dut_b (
      .i_clk (clk),
      .i_rst (rst_b),
      .bus   (b_if)
   );

   // Memories: write at the edge ending the o_m_valid cycle, read data appears RD_LAT cycles later.
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   logic [31:0] pipe_a;
   logic [31:0] pipe_b [4];

   always @(posedge clk) begin
      if (a_if.o_m_valid && a_if.o_m_we) mem_a[a_if.o_m_addr[7:0]] <= a_if.o_m_data;
      pipe_a <= mem_a[a_if.o_m_addr[7:0]];
      if (b_if.o_m_valid && b_if.o_m_we) mem_b[b_if.o_m_addr[7:0]] <= b_if.o_m_data;
      pipe_b[0] <= mem_b[b_if.o_m_addr[7:0]];
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
      pipe_b[3] <= pipe_b[2];
   end

   assign a_if.i_m_data = pipe_a;
   assign b_if.i_m_data = pipe_b[3];

   task automatic clear_inputs();
      a_if.i_req_valid = '0;
      a_if.i_req_we    = '0;
      a_if.i_req_addr  = '0;
      a_if.i_req_data  = '0;
      b_if.i_req_valid = '0;
      b_if.i_req_we    = '0;
      b_if.i_req_addr  = '0;
      b_if.i_req_data  = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      clear_inputs();
      repeat (n) next_cycle();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_a = 1'b0;
      rst_b = 1'b0;
      a_if.i_req_valid = '1;
      b_if.i_req_valid = '1;
      next_cycle();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (a_if.o_req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready_a: got %b expected 0000", a_if.o_req_ready);
         end
         n_checks++;
         if (b_if.o_req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready_b: got %b expected 0000", b_if.o_req_ready);
         end
         n_checks++;
         if (a_if.o_m_valid !== 1'b0 || a_if.o_m_we !== 1'b0 || b_if.o_m_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_m_valid: got a=%b/%b b=%b expected 0", a_if.o_m_valid, a_if.o_m_we, b_if.o_m_valid);
         end
         n_checks++;
         if (a_if.o_rsp_valid !== 4'b0000 || b_if.o_rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_rsp_valid: got a=%b b=%b expected 0000", a_if.o_rsp_valid, b_if.o_rsp_valid);
         end
         n_checks++;
         if (a_if.o_m_addr !== 32'h0 || a_if.o_m_data !== 32'h0 || a_if.o_rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_data_regs: got addr=%h data=%h rsp=%h expected 0", a_if.o_m_addr, a_if.o_m_data, a_if.o_rsp_data);
         end
         next_cycle();
      end
      rst_a = 1'b1;
      rst_b = 1'b1;
      @(negedge clk);
      n_checks++;
      if (a_if.o_req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL first_grant_rr: got %b expected 0001", a_if.o_req_ready);
      end
      n_checks++;
      if (b_if.o_req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL first_grant_fp: got %b expected 0001", b_if.o_req_ready);
      end
      next_cycle();
      idle(10);
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 8; c++) begin
         clear_inputs();
         if (c < 4) begin
            a_if.i_req_valid[2]       = 1'b1;
            a_if.i_req_addr[2*AW +: AW] = 32'h10 + 32'(c);
         end
         @(negedge clk);
         if (c < 4) begin
            n_checks++;
            if (a_if.o_req_ready !== 4'b0100) begin
               n_fail++; $display("FAIL b2b_ready c=%0d: got %b expected 0100", c, a_if.o_req_ready);
            end
         end
         if (c >= 1 && c <= 4) begin
            n_checks++;
            if (a_if.o_m_valid !== 1'b1 || a_if.o_m_addr !== 32'h10 + 32'(c - 1)) begin
               n_fail++; $display("FAIL b2b_mem_req c=%0d: got v=%b addr=%h expected v=1 addr=%h",
                                  c, a_if.o_m_valid, a_if.o_m_addr, 32'h10 + 32'(c - 1));
            end
         end
         n_checks++;
         if (c >= 3 && c <= 6) begin
            if (a_if.o_rsp_valid !== 4'b0100 || a_if.o_rsp_data !== 32'hA0 + 32'(c - 3)) begin
               n_fail++; $display("FAIL b2b_rsp c=%0d: got v=%b d=%h expected v=0100 d=%h",
                                  c, a_if.o_rsp_valid, a_if.o_rsp_data, 32'hA0 + 32'(c - 3));
            end
         end else if (a_if.o_rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_rsp_idle c=%0d: got %b expected 0000", c, a_if.o_rsp_valid);
         end
         if (c == 7) begin
            n_checks++;
            if (a_if.o_rsp_data !== 32'hA3) begin
               n_fail++; $display("FAIL rsp_data_hold: got %h expected 000000a3", a_if.o_rsp_data);
            end
         end
         next_cycle();
      end
      idle(4);
   endtask

   task automatic test_round_robin();
      int         cnt [4];
      logic [3:0] exp_g;
      for (int p = 0; p < 4; p++) cnt[p] = 0;
      clear_inputs();
      rst_a = 1'b0;
      next_cycle();
      rst_a = 1'b1;
      a_if.i_req_valid = '1;
      a_if.i_req_we    = '1;
      for (int p = 0; p < 4; p++) begin
         a_if.i_req_addr[p*AW +: AW] = 32'hF0 + 32'(p);
         a_if.i_req_data[p*DW +: DW] = 32'h100 + 32'(p);
      end
      for (int c = 0; c < 100; c++) begin
         exp_g = 4'b0001 << (c % 4);
         @(negedge clk);
         n_checks++;
         if (a_if.o_req_ready !== exp_g) begin
            n_fail++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, a_if.o_req_ready, exp_g);
         end
         n_checks++;
         if (a_if.o_rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL write_no_rsp c=%0d: got %b expected 0000", c, a_if.o_rsp_valid);
         end
         for (int p = 0; p < 4; p++) if (a_if.o_req_ready[p] === 1'b1) cnt[p]++;
         next_cycle();
      end
      clear_inputs();
      for (int p = 0; p < 4; p++) begin
         n_checks++;
         if (cnt[p] != 25) begin
            n_fail++; $display("FAIL rr_share port%0d: got %0d grants expected 25", p, cnt[p]);
         end
      end
      idle(4);
   endtask

   task automatic test_fixed_priority();
      logic [3:0] exp_g;
      clear_inputs();
      b_if.i_req_valid              = 4'b1010;
      b_if.i_req_addr[1*AW +: AW]   = 32'h20;
      b_if.i_req_addr[3*AW +: AW]   = 32'h30;
      for (int c = 0; c < 8; c++) begin
         if (c == 5) b_if.i_req_valid[1] = 1'b0;
         exp_g = (c < 5) ? 4'b0010 : 4'b1000;
         @(negedge clk);
         n_checks++;
         if (b_if.o_req_ready !== exp_g) begin
            n_fail++; $display("FAIL fp_grant c=%0d: got %b expected %b", c, b_if.o_req_ready, exp_g);
         end
         next_cycle();
      end
      idle(10);
   endtask

   task automatic test_write_read_cross();
      for (int c = 0; c < 7; c++) begin
         clear_inputs();
         if (c == 0) begin
            a_if.i_req_valid[0]         = 1'b1;
            a_if.i_req_we[0]            = 1'b1;
            a_if.i_req_addr[0*AW +: AW] = 32'h40;
            a_if.i_req_data[0*DW +: DW] = 32'hDEADBEEF;
         end
         if (c == 1) begin
            a_if.i_req_valid[1]         = 1'b1;
            a_if.i_req_addr[1*AW +: AW] = 32'h40;
         end
         @(negedge clk);
         if (c == 0 || c == 1) begin
            n_checks++;
            if (a_if.o_req_ready !== ((c == 0) ? 4'b0001 : 4'b0010)) begin
               n_fail++; $display("FAIL raw_ready c=%0d: got %b expected %b", c, a_if.o_req_ready,
                                  (c == 0) ? 4'b0001 : 4'b0010);
            end
         end
         if (c == 1) begin
            n_checks++;
            if (a_if.o_m_valid !== 1'b1 || a_if.o_m_we !== 1'b1 || a_if.o_m_data !== 32'hDEADBEEF) begin
               n_fail++; $display("FAIL raw_mem_write: got v=%b we=%b d=%h expected 1/1/deadbeef",
                                  a_if.o_m_valid, a_if.o_m_we, a_if.o_m_data);
            end
         end
         n_checks++;
         if (c == 4) begin
            if (a_if.o_rsp_valid !== 4'b0010 || a_if.o_rsp_data !== 32'hDEADBEEF) begin
               n_fail++; $display("FAIL raw_rsp: got v=%b d=%h expected v=0010 d=deadbeef",
                                  a_if.o_rsp_valid, a_if.o_rsp_data);
            end
         end else if (a_if.o_rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL raw_rsp_idle c=%0d: got %b expected 0000", c, a_if.o_rsp_valid);
         end
         next_cycle();
      end
      idle(4);
   endtask

   task automatic test_reset_mid_flight();
      for (int c = 0; c < 12; c++) begin
         clear_inputs();
         rst_b = (c == 2) ? 1'b0 : 1'b1;
         if (c == 0) begin
            b_if.i_req_valid[0]         = 1'b1;
            b_if.i_req_addr[0*AW +: AW] = 32'h50;
         end
         @(negedge clk);
         if (c == 0) begin
            n_checks++;
            if (b_if.o_req_ready !== 4'b0001) begin
               n_fail++; $display("FAIL flight_ready: got %b expected 0001", b_if.o_req_ready);
            end
         end
         n_checks++;
         if (b_if.o_rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL flight_dropped c=%0d: got %b expected 0000", c, b_if.o_rsp_valid);
         end
         next_cycle();
      end
      rst_b = 1'b1;
      for (int c = 0; c < 8; c++) begin
         clear_inputs();
         if (c == 0) begin
            b_if.i_req_valid[2]         = 1'b1;
            b_if.i_req_addr[2*AW +: AW] = 32'h51;
         end
         @(negedge clk);
         if (c == 0) begin
            n_checks++;
            if (b_if.o_req_ready !== 4'b0100) begin
               n_fail++; $display("FAIL post_rst_ready: got %b expected 0100", b_if.o_req_ready);
            end
         end
         n_checks++;
         if (c == 6) begin
            if (b_if.o_rsp_valid !== 4'b0100 || b_if.o_rsp_data !== 32'h55550051) begin
               n_fail++; $display("FAIL post_rst_rsp: got v=%b d=%h expected v=0100 d=55550051",
                                  b_if.o_rsp_valid, b_if.o_rsp_data);
            end
         end else if (b_if.o_rsp_valid !== 4'b0000) begin
            n_fail++; $display("FAIL post_rst_rsp_idle c=%0d: got %b expected 0000", c, b_if.o_rsp_valid);
         end
         next_cycle();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 32'h0;
         mem_b[i] = 32'h0;
      end
      for (int i = 0; i < 4; i++) mem_a[16 + i] = 32'hA0 + 32'(i);
      mem_b[8'h50] = 32'h55550050;
      mem_b[8'h51] = 32'h55550051;

      test_reset();
      test_back_to_back();
      test_round_robin();
      test_fixed_priority();
      test_write_read_cross();
      test_reset_mid_flight();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
